alu_sequencer: RTL and testbench

Single-button front-end controller for the combinational ALU on the board. It debounces one push-button, then steps through a fixed sequence: load operand A, load operand B, load the opcode, show the result. Each step is taken from the shared switch bank `valor`. It drives the ALU's `A`/`B`/`Op` inputs from its own registers, and latches the ALU output into a result register that drives the LEDs. It replaces the three-button direct-load scheme.

---
 rtl/alu_sequencer_pkg.sv | 23 ++
 rtl/alu_sequencer_debounce.sv | 55 +++++
 rtl/alu_sequencer.sv | 83 ++++++++
 tb/tb_alu_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU front-end: opcode width, the ALU opcode
// constants, and the sequencer step encodings.
package alu_defs;

  localparam int op_width = 6;

  localparam logic [op_width-1:0] OP_ADD = 6'b100000;
  localparam logic [op_width-1:0] OP_SUB = 6'b100010;
  localparam logic [op_width-1:0] OP_AND = 6'b100100;
  localparam logic [op_width-1:0] OP_OR  = 6'b100101;
  localparam logic [op_width-1:0] OP_XOR = 6'b100110;
  localparam logic [op_width-1:0] OP_NOR = 6'b100111;
  localparam logic [op_width-1:0] OP_SRA = 6'b000011;
  localparam logic [op_width-1:0] OP_SRL = 6'b000010;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    SHOW    = 2'd3
  } step_t;

endpackage

// File: rtl/alu_sequencer_debounce.sv
// Button conditioner: 2-flop synchronizer, stable-level debouncer, rising-edge pulse.
// Latency: raw edge to press = 2 + debounce_cycles cycles.
// No backpressure; press is a single-cycle pulse per accepted rising level.
module debounce #(
  parameter int debounce_cycles = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int cnt_w = $clog2(debounce_cycles);

  logic             sync_1;
  logic             btn_s;
  logic             btn_db;
  logic             btn_db_prev;
  logic [cnt_w-1:0] cnt;

  // Bring the raw button into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      sync_1 <= btn;
      btn_s  <= sync_1;
    end
  end

  // Accept a level change only after it has been stable for debounce_cycles cycles;
  // any return to the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_db      <= 1'b0;
      btn_db_prev <= 1'b0;
      cnt         <= '0;
    end else begin
      btn_db_prev <= btn_db;
      if (btn_s == btn_db) begin
        cnt <= '0;
      end else if (cnt == cnt_w'(debounce_cycles - 1)) begin
        btn_db <= ~btn_db;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Only the press (rising) edge of the debounced level is reported.
  assign press = btn_db & ~btn_db_prev;

endmodule

// File: rtl/alu_sequencer.sv
// Single-button sequencer loading ALU operand A, operand B, opcode, then showing the result.
// Latency: loads visible 1 cycle after press; leds/result_valid 2 cycles after the opcode press.
// No backpressure; a press is consumed in whatever step is current.
module alu_sequencer
  import alu_defs::*;
#(
  parameter int size            = 8,
  parameter int op_width        = alu_defs::op_width,
  parameter int debounce_cycles = 1_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic        [size-1:0]     valor,
  input  logic                       btn,
  output logic signed [size-1:0]     alu_a,
  output logic signed [size-1:0]     alu_b,
  output logic        [op_width-1:0] alu_op,
  input  logic signed [size-1:0]     alu_result,
  output logic signed [size-1:0]     leds,
  output logic        [1:0]          state,
  output logic                       result_valid
);

  logic  press;
  logic  capture;
  step_t step;

  debounce #(
    .debounce_cycles(debounce_cycles)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .btn  (btn),
    .press(press)
  );

  // Step through the loads on each press; the result is captured one cycle after
  // entering SHOW so the ALU sees the freshly loaded opcode first.
  always_ff @(posedge clk) begin
    if (reset) begin
      step         <= LOAD_A;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      leds         <= '0;
      result_valid <= 1'b0;
      capture      <= 1'b0;
    end else begin
      if (capture) begin
        leds         <= alu_result;
        result_valid <= 1'b1;
        capture      <= 1'b0;
      end
      if (press) begin
        unique case (step)
          LOAD_A: begin
            alu_a        <= valor;
            result_valid <= 1'b0;
            step         <= LOAD_B;
          end
          LOAD_B: begin
            alu_b        <= valor;
            result_valid <= 1'b0;
            step         <= LOAD_OP;
          end
          LOAD_OP: begin
            alu_op       <= valor[op_width-1:0];
            result_valid <= 1'b0;
            capture      <= 1'b1;
            step         <= SHOW;
          end
          SHOW: begin
            step <= LOAD_A;
          end
          default: step <= LOAD_A;
        endcase
      end
    end
  end

  assign state = step;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with debounce_cycles = 4 and a behavioural ALU.
module tb_alu_sequencer;
  import alu_defs::*;

  localparam int D = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic        [7:0] valor;
  logic              btn;
  logic signed [7:0] alu_a;
  logic signed [7:0] alu_b;
  logic        [5:0] alu_op;
  logic signed [7:0] alu_result;
  logic signed [7:0] leds;
  logic        [1:0] state;
  logic              result_valid;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_sequencer #(
    .size(8),
    .op_width(6),
    .debounce_cycles(D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .valor       (valor),
    .btn         (btn),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .leds        (leds),
    .state       (state),
    .result_valid(result_valid)
  );

  // Behavioural combinational ALU driven by the sequencer registers.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_NOR:  alu_result = ~(alu_a | alu_b);
      OP_SRA:  alu_result = alu_a >>> alu_b[2:0];
      OP_SRL:  alu_result = alu_a >> alu_b[2:0];
      default: alu_result = '0;
    endcase
  end

  typedef struct {
    logic [7:0] valor;
    logic [1:0] st;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] leds;
    logic       valid;
  } vec_t;

  vec_t tbl[9];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".state"}, {6'b0, state}, {6'b0, v.st});
    chk({tag, ".alu_a"}, alu_a, v.a);
    chk({tag, ".alu_b"}, alu_b, v.b);
    chk({tag, ".alu_op"}, {2'b0, alu_op}, {2'b0, v.op});
    chk({tag, ".leds"}, leds, v.leds);
    chk({tag, ".valid"}, {7'b0, result_valid}, {7'b0, v.valid});
  endtask

  // Clean press: hold well past acceptance, then release well past acceptance.
  task automatic press_full(input logic [7:0] v);
    valor = v;
    btn   = 1'b1;
    tick(10);
    btn   = 1'b0;
    tick(10);
  endtask

  initial begin
    int        changes;
    logic [1:0] prev;
    logic [1:0] st6;
    logic [1:0] st7;
    vec_t      zero_v;

    //          valor  st    a      b      op     leds   valid
    tbl[0] = '{8'h03, 2'd2, 8'h05, 8'h03, 6'h00, 8'h00, 1'b0};
    tbl[1] = '{8'h22, 2'd3, 8'h05, 8'h03, 6'h22, 8'h02, 1'b1};  // 5 - 3
    tbl[2] = '{8'hFF, 2'd0, 8'h05, 8'h03, 6'h22, 8'h02, 1'b1};  // wrap, leds hold
    tbl[3] = '{8'h80, 2'd1, 8'h80, 8'h03, 6'h22, 8'h02, 1'b0};  // A = -128 clears valid
    tbl[4] = '{8'h05, 2'd2, 8'h80, 8'h05, 6'h22, 8'h02, 1'b0};
    tbl[5] = '{8'hE5, 2'd3, 8'h80, 8'h05, 6'h25, 8'h85, 1'b1};  // upper bits dropped, OR
    tbl[6] = '{8'h00, 2'd0, 8'h80, 8'h05, 6'h25, 8'h85, 1'b1};
    tbl[7] = '{8'h07, 2'd1, 8'h07, 8'h05, 6'h25, 8'h85, 1'b0};
    tbl[8] = '{8'h02, 2'd2, 8'h07, 8'h02, 6'h25, 8'h85, 1'b0};
    zero_v = '{8'h00, 2'd0, 8'h00, 8'h00, 6'h00, 8'h00, 1'b0};

    // Reset
    reset = 1'b1;
    btn   = 1'b0;
    valor = 8'h00;
    tick(2);
    chk_all("reset", zero_v);
    reset = 1'b0;
    tick(2);

    // Bounce rejection: 2-cycle pulses never survive the 4-cycle filter
    changes = 0;
    prev    = state;
    valor   = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      tick(2);
      if (state != prev) changes++;
      prev = state;
    end
    btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (state != prev) changes++;
      prev = state;
    end
    chk("bounce.changes", 8'(changes), 8'd0);
    chk("bounce.state", {6'b0, state}, 8'd0);
    chk("bounce.alu_a", alu_a, 8'h00);

    // Hold: one press only, state moves exactly D+3 edges after btn rises
    valor   = 8'h05;
    btn     = 1'b1;
    changes = 0;
    prev    = state;
    st6     = 2'd0;
    st7     = 2'd0;
    for (int i = 1; i <= 100; i++) begin
      tick(1);
      if (i == D + 2) st6 = state;
      if (i == D + 3) st7 = state;
      if (state != prev) changes++;
      prev = state;
    end
    btn = 1'b0;
    tick(10);
    chk("hold.state_before", {6'b0, st6}, 8'd0);
    chk("hold.state_at", {6'b0, st7}, 8'd1);
    chk("hold.changes", 8'(changes), 8'd1);
    chk("hold.alu_a", alu_a, 8'h05);

    // Table-driven loads continuing from LOAD_B
    for (int i = 0; i < 9; i++) begin
      press_full(tbl[i].valor);
      chk_all($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset in the same cycle as a LOAD_OP press
    valor = 8'h26;
    btn   = 1'b1;
    tick(D + 2);
    reset = 1'b1;
    btn   = 1'b0;
    tick(1);
    chk_all("rst_midop", zero_v);
    reset = 1'b0;
    tick(10);
    chk("rst_midop.after", {6'b0, state}, 8'd0);

    // Exact LOAD_OP timing: state at n+1, result at n+2
    press_full(8'h05);
    press_full(8'h03);
    valor = 8'h22;
    btn   = 1'b1;
    tick(D + 3);
    chk("opt.state_n1", {6'b0, state}, 8'd3);
    chk("opt.op_n1", {2'b0, alu_op}, 8'h22);
    chk("opt.valid_n1", {7'b0, result_valid}, 8'd0);
    chk("opt.leds_n1", leds, 8'h00);
    tick(1);
    chk("opt.valid_n2", {7'b0, result_valid}, 8'd1);
    chk("opt.leds_n2", leds, 8'h02);
    btn = 1'b0;
    tick(10);

    // Button held through reset release: single press, state moves D+3 edges later
    btn   = 1'b1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(D + 2);
    chk("hrst.state_before", {6'b0, state}, 8'd0);
    tick(1);
    chk("hrst.state_at", {6'b0, state}, 8'd1);
    tick(50);
    chk("hrst.state_held", {6'b0, state}, 8'd1);
    btn = 1'b0;
    tick(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
